// File: rtl/lcd_timer_pkg.sv
// lcd_timer_pkg
// Shared types and constants for the LCD interval timer.
//   timer_state_t : FSM states (IDLE, COUNT, DONE), 2-bit encoding
//   MODE_ONESHOT  : mode value for a single expiry followed by DONE
//   MODE_PERIODIC : mode value for repeated expiries until stop
package lcd_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } timer_state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/lcd_timer_prescaler.sv
// lcd_timer_prescaler
// Divides the system clock into a base time unit. The count runs from 0 to
// PRESCALE-1 while run is high and wraps. strobe is asserted during the
// final cycle of each base unit, so the consumer acts on it at the edge
// where the count wraps.
// Ports:
//   clock  in  system clock, rising edge
//   rst    in  synchronous, active-low reset
//   clr    in  zero the count (has priority over run)
//   run    in  advance the count
//   strobe out one-cycle pulse on wrap
module lcd_timer_prescaler #(
    parameter int PRESCALE = 50,
    parameter int PRE_W    = 16
) (
    input  logic clock,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic strobe
);

    localparam logic [PRE_W-1:0] LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] count_q;
    logic [PRE_W-1:0] count_d;

    // A clear on the same edge suppresses the wrap, so no strobe then.
    assign strobe = run && !clr && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (run) begin
            count_d = (count_q == LAST) ? '0 : count_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/lcd_interval_timer.sv
// lcd_interval_timer
// Programmable interval timer for LCD controller delays. A prescaler yields
// a base unit of PRESCALE clocks; a down-counter counts `interval` base
// units (0 treated as 1). One-shot mode ends in DONE with a sticky done
// flag; periodic mode reloads and ticks every interval until stopped.
// start while counting retriggers; stop always wins over start.
// Optional feature macro: TIMER_REMAIN_EN adds the `remaining` port.
// Ports:
//   clock     in   system clock, rising edge
//   rst       in   synchronous, active-low reset
//   start     in   load interval/mode and begin counting
//   stop      in   abort, return to IDLE
//   mode      in   0 one-shot, 1 periodic (sampled with start)
//   interval  in   base units per period (sampled with start)
//   busy      out  high while counting
//   tick      out  one-cycle pulse at each expiry
//   done      out  sticky one-shot completion flag
//   remaining out  base units left (TIMER_REMAIN_EN only)
module lcd_interval_timer
    import lcd_timer_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int PRESCALE = 50,
    parameter int PRE_W    = 16
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [CNT_W-1:0] interval,
    output logic             busy,
    output logic             tick,
    output logic             done
`ifdef TIMER_REMAIN_EN
    ,
    output logic [CNT_W-1:0] remaining
`endif
);

    timer_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] ival_q, ival_d;
    logic             mode_q, mode_d;
    logic             busy_q, busy_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic             strobe;

    // start and stop both restart the base-unit phase, which is what
    // keeps retriggered timing aligned to the retrigger edge.
    lcd_timer_prescaler #(
        .PRESCALE (PRESCALE),
        .PRE_W    (PRE_W)
    ) u_prescaler (
        .clock  (clock),
        .rst    (rst),
        .clr    (start || stop),
        .run    (state_q == COUNT),
        .strobe (strobe)
    );

    // Priority: stop, then start (load/retrigger), then expiry handling.
    // The counter holds 1 on the final base unit, so expiry is detected on
    // the strobe that sees 1; it is reloaded or cleared rather than
    // decremented, so it never underflows.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ival_d  = ival_q;
        mode_d  = mode_q;
        busy_d  = busy_q;
        done_d  = done_q;
        tick_d  = 1'b0;

        if (stop) begin
            state_d = IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end else if (start) begin
            ival_d  = (interval == '0) ? CNT_W'(1) : interval;
            mode_d  = mode;
            cnt_d   = ival_d;
            state_d = COUNT;
            busy_d  = 1'b1;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                COUNT: begin
                    if (strobe) begin
                        if (cnt_q == CNT_W'(1)) begin
                            tick_d = 1'b1;
                            if (mode_q == MODE_PERIODIC) begin
                                cnt_d = ival_q;
                            end else begin
                                state_d = DONE;
                                cnt_d   = '0;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
                IDLE, DONE: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ival_q  <= '0;
            mode_q  <= MODE_ONESHOT;
            busy_q  <= 1'b0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ival_q  <= ival_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign tick = tick_q;
    assign done = done_q;

`ifdef TIMER_REMAIN_EN
    assign remaining = cnt_q;
`endif

endmodule

// File: tb/tb_lcd_interval_timer.sv
// tb_lcd_interval_timer
// Scoreboarded bench for lcd_interval_timer (PRESCALE=4, CNT_W=8) plus a
// short directed check of a PRESCALE=1 instance. A reference model turns
// each start into an absolute expiry deadline (start edge + N*PRESCALE)
// and pushes the expected outputs per edge; a separate monitor pops and
// compares one cycle's outputs shortly after each rising edge.
module tb_lcd_interval_timer;
    import lcd_timer_pkg::*;

    localparam int P     = 4;
    localparam int CNT_W = 8;

    typedef struct {
        bit busy;
        bit tick;
        bit done;
        int remaining;
    } exp_t;

    logic             clock = 1'b0;
    logic             rst_i = 1'b0;
    logic             start_i = 1'b0;
    logic             stop_i = 1'b0;
    logic             mode_i = 1'b0;
    logic [CNT_W-1:0] interval_i = '0;
    logic             busy_o, tick_o, done_o;
    logic [CNT_W-1:0] remaining_o;

    logic             p1_rst = 1'b0;
    logic             p1_start = 1'b0;
    logic             p1_stop = 1'b0;
    logic             p1_mode = 1'b0;
    logic [CNT_W-1:0] p1_interval = '0;
    logic             p1_busy, p1_tick, p1_done;
    logic [CNT_W-1:0] p1_remaining;

    exp_t sb[$];
    int   checkCount = 0;
    int   passCount  = 0;
    int   failCount  = 0;

    always #5 clock = ~clock;

    lcd_interval_timer #(.CNT_W(CNT_W), .PRESCALE(P), .PRE_W(4)) dut (
        .clock     (clock),
        .rst       (rst_i),
        .start     (start_i),
        .stop      (stop_i),
        .mode      (mode_i),
        .interval  (interval_i),
        .busy      (busy_o),
        .tick      (tick_o),
        .done      (done_o)
`ifdef TIMER_REMAIN_EN
        ,
        .remaining (remaining_o)
`endif
    );

    lcd_interval_timer #(.CNT_W(CNT_W), .PRESCALE(1), .PRE_W(1)) dut_p1 (
        .clock     (clock),
        .rst       (p1_rst),
        .start     (p1_start),
        .stop      (p1_stop),
        .mode      (p1_mode),
        .interval  (p1_interval),
        .busy      (p1_busy),
        .tick      (p1_tick),
        .done      (p1_done)
`ifdef TIMER_REMAIN_EN
        ,
        .remaining (p1_remaining)
`endif
    );

`ifndef TIMER_REMAIN_EN
    assign remaining_o  = '0;
    assign p1_remaining = '0;
`endif

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: time is measured in edges. A start fixes an absolute
    // deadline; each expiry either moves it one period on or ends the run.
    int edgeNum    = 0;
    bit mActive    = 0;
    bit mPeriodic  = 0;
    bit mDone      = 0;
    int mPeriod    = 0;
    int mDeadline  = 0;

    always @(posedge clock) begin
        exp_t e;
        int   n;
        edgeNum++;
        e.tick = 0;
        if (!rst_i || stop_i) begin
            mActive = 0;
            mDone   = 0;
        end else if (start_i) begin
            n         = (interval_i == 0) ? 1 : int'(interval_i);
            mPeriod   = n * P;
            mDeadline = edgeNum + mPeriod;
            mPeriodic = (mode_i == MODE_PERIODIC);
            mActive   = 1;
            mDone     = 0;
        end else if (mActive && edgeNum == mDeadline) begin
            e.tick = 1;
            if (mPeriodic) begin
                mDeadline += mPeriod;
            end else begin
                mActive = 0;
                mDone   = 1;
            end
        end
        e.busy      = mActive;
        e.done      = mDone;
        e.remaining = mActive ? (mDeadline - edgeNum + P - 1) / P : 0;
        sb.push_back(e);
    end

    // Monitor: one expected record per edge, compared 1 time unit later.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (sb.size() == 0) begin
            checkOutput("scoreboard_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            checkOutput("busy", int'(busy_o), int'(e.busy));
            checkOutput("tick", int'(tick_o), int'(e.tick));
            checkOutput("done", int'(done_o), int'(e.done));
`ifdef TIMER_REMAIN_EN
            checkOutput("remaining", int'(remaining_o), e.remaining);
`endif
        end
    end

    // Drive one cycle of inputs, then idle inputs for the rest of `cycles`.
    task automatic applyStimulus(input bit r, input bit s, input bit p, input bit m,
                                 input int iv, input int cycles);
        rst_i      = r;
        start_i    = s;
        stop_i     = p;
        mode_i     = m;
        interval_i = CNT_W'(iv);
        @(negedge clock);
        rst_i   = 1'b1;
        start_i = 1'b0;
        stop_i  = 1'b0;
        repeat (cycles - 1) @(negedge clock);
    endtask

    initial begin
        $display("[TB] lcd_interval_timer bench start");
        applyStimulus(0, 0, 0, 0, 0, 3);

        // One-shot, interval 3: tick after edge 12, done sticky afterwards.
        applyStimulus(1, 1, 0, MODE_ONESHOT, 3, 20);
        // Periodic, interval 2: ticks every 8 edges, stop at edge 34.
        applyStimulus(1, 1, 0, MODE_PERIODIC, 2, 34);
        applyStimulus(1, 0, 1, 0, 0, 41);
        // Interval 0 behaves as 1.
        applyStimulus(1, 1, 0, MODE_ONESHOT, 0, 8);
        // Retrigger: 5 units, then 2 units at edge 10.
        applyStimulus(1, 1, 0, MODE_ONESHOT, 5, 10);
        applyStimulus(1, 1, 0, MODE_ONESHOT, 2, 16);
        // Start from DONE, then stop from DONE.
        applyStimulus(1, 1, 0, MODE_ONESHOT, 1, 6);
        applyStimulus(1, 0, 1, 0, 0, 3);
        // Simultaneous start and stop.
        applyStimulus(1, 1, 1, MODE_PERIODIC, 2, 12);
        // Reset at edge 6 of a 3-unit count.
        applyStimulus(1, 1, 0, MODE_ONESHOT, 3, 6);
        applyStimulus(0, 0, 0, 0, 0, 21);

        // Randomized traffic with occasional retrigger, stop and reset.
        for (int i = 0; i < 2500; i++) begin
            int r;
            r = $urandom_range(0, 99);
            applyStimulus(r != 0, (r >= 1 && r <= 5) || r == 8, (r >= 6 && r <= 8),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 9) == 0) ? $urandom_range(7, 20) : $urandom_range(0, 6),
                          1);
        end
        applyStimulus(1, 0, 1, 0, 0, 2);

        // PRESCALE=1, interval 1, periodic: tick every cycle.
        p1_rst      = 1'b1;
        p1_start    = 1'b1;
        p1_mode     = MODE_PERIODIC;
        p1_interval = CNT_W'(1);
        @(negedge clock);
        p1_start = 1'b0;
        checkOutput("p1_busy_first", int'(p1_busy), 1);
        checkOutput("p1_tick_first", int'(p1_tick), 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            checkOutput("p1_tick_every", int'(p1_tick), 1);
            checkOutput("p1_busy_every", int'(p1_busy), 1);
`ifdef TIMER_REMAIN_EN
            checkOutput("p1_remaining", int'(p1_remaining), 1);
`endif
        end
        p1_stop = 1'b1;
        @(negedge clock);
        p1_stop = 1'b0;
        checkOutput("p1_busy_stop", int'(p1_busy), 0);
        checkOutput("p1_tick_stop", int'(p1_tick), 0);
        checkOutput("p1_done_stop", int'(p1_done), 0);

        @(negedge clock);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
